// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Walks a program counter through instruction
// memory with at most one outstanding request. Each returned word goes to the
// dispatch instruction FIFO as {pc, insn}. If the FIFO is full when a response
// arrives, the word is parked in a one-entry hold register. A redirect from the
// ROB (mispredicted branch) overrides everything. A response that is still in
// flight when a redirect lands is discarded.
//
// Parameters
//   DATA_WIDTH  instruction word width
//   ADDR_WIDTH  program counter width
//   RESET_ADDR  first fetch address after reset (word aligned)
//
// Ports
//   clk              in   clock, rising edge
//   n_rst            in   asynchronous active-low reset
//   i_redirect       in   redirect pulse from the ROB
//   i_redirect_addr  in   new fetch PC; bits [1:0] are ignored
//   o_ic_req         out  instruction-memory request valid
//   o_ic_addr        out  request address (current PC)
//   i_ic_ack         in   memory accepted the request this cycle
//   i_ic_valid       in   response data valid
//   i_ic_data        in   fetched instruction
//   o_fifo_wr_en     out  write strobe into the instruction FIFO
//   o_fifo_data_in   out  {pc, insn}, PC in the upper ADDR_WIDTH bits
//   i_fifo_full      in   instruction FIFO full
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             i_redirect,
  input  logic [ADDR_WIDTH-1:0]            i_redirect_addr,
  output logic                             o_ic_req,
  output logic [ADDR_WIDTH-1:0]            o_ic_addr,
  input  logic                             i_ic_ack,
  input  logic                             i_ic_valid,
  input  logic [DATA_WIDTH-1:0]            i_ic_data,
  output logic                             o_fifo_wr_en,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_fifo_data_in,
  input  logic                             i_fifo_full
);

  typedef enum logic [1:0] {
    S_REQ,      // request the word at pc
    S_WAIT,     // request accepted, waiting for the response
    S_HOLD,     // response parked in hold_q until the FIFO has room
    S_DISCARD   // a redirect orphaned the in-flight request; drop its response
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                             state;
  logic [ADDR_WIDTH-1:0]              pc;
  logic [ADDR_WIDTH-1:0]              req_pc;   // address of the outstanding request
  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   hold_q;   // {pc, insn} waiting for FIFO space
  logic [ADDR_WIDTH-1:0]              redirect_pc;

  // Redirect targets are forced onto a word boundary.
  assign redirect_pc = i_redirect_addr & ALIGN_MASK;

  // The request and the FIFO write are combinational, so a response can be
  // written in the same cycle it arrives. The request is gated with n_rst
  // because the state register sits in S_REQ throughout reset.
  assign o_ic_req  = n_rst && (state == S_REQ) && !i_redirect;
  assign o_ic_addr = pc;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    o_fifo_wr_en   = 1'b0;
    o_fifo_data_in = {req_pc, i_ic_data};
    if (!i_redirect && !i_fifo_full) begin
      unique case (state)
        S_WAIT: o_fifo_wr_en = i_ic_valid;
        S_HOLD: begin
          o_fifo_wr_en   = 1'b1;
          o_fifo_data_in = hold_q;
        end
        default: o_fifo_wr_en = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // Reset abandons any outstanding request. Responses that arrive while
      // reset is held are ignored, because these assignments dominate.
      state  <= S_REQ;
      pc     <= RESET_ADDR;
      req_pc <= '0;
      hold_q <= '0;
    end else if (i_redirect) begin
      pc <= redirect_pc;
      unique case (state)
        // A request is still in flight. Wait for its response and drop it,
        // unless that response is arriving right now.
        S_WAIT, S_DISCARD: state <= i_ic_valid ? S_REQ : S_DISCARD;
        // In S_HOLD, leaving the state drops the parked instruction.
        default:           state <= S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          // A response in this state is a protocol violation and is ignored.
          if (i_ic_ack) begin
            req_pc <= pc;
            pc     <= pc + PC_STEP;   // wraps modulo 2^ADDR_WIDTH
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_ic_valid) begin
            if (i_fifo_full) begin
              hold_q <= {req_pc, i_ic_data};
              state  <= S_HOLD;
            end else begin
              state  <= S_REQ;         // written combinationally this cycle
            end
          end
        end
        S_HOLD: begin
          if (!i_fifo_full) state <= S_REQ;
        end
        S_DISCARD: begin
          if (i_ic_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 32, PC width.
REQ-003 Parameter RESET_ADDR, default 0, first fetch address after reset; word aligned.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 i_redirect  in  1  ROB redirect pulse, e.g. from a mispredicted branch.
REQ-007 i_redirect_addr  in  ADDR_WIDTH  new fetch PC; meaningful only when i_redirect=1.
REQ-008 o_ic_req  out  1  instruction-memory request valid.
REQ-009 o_ic_addr  out  ADDR_WIDTH  request address; equals current PC.
REQ-010 i_ic_ack  in  1  memory accepted the request this cycle; meaningful only when o_ic_req=1.
REQ-011 i_ic_valid  in  1  response data valid.
REQ-012 i_ic_data  in  DATA_WIDTH  fetched instruction.
REQ-013 o_fifo_wr_en  out  1  write strobe to the instruction FIFO feeding dispatch.
REQ-014 o_fifo_data_in  out  ADDR_WIDTH+DATA_WIDTH  {pc, insn}; PC in the upper ADDR_WIDTH bits.
REQ-015 i_fifo_full  in  1  instruction FIFO full.

Function
REQ-016 The block SHALL implement FSM states REQ, WAIT, HOLD and DISCARD, with at most one outstanding memory request.
REQ-017 REQ: o_ic_req=1 unless i_redirect=1; on i_ic_ack, latch req_pc<=pc, set pc<=pc+4 (mod 2^ADDR_WIDTH, wrap at max), go to WAIT.
REQ-018 WAIT, i_ic_valid=1, i_fifo_full=0: same-cycle combinational write o_fifo_wr_en=1, data {req_pc, i_ic_data}; go to REQ.
REQ-019 WAIT, i_ic_valid=1, i_fifo_full=1: capture {req_pc, i_ic_data} in the hold register; go to HOLD; no write.
REQ-020 HOLD: o_fifo_wr_en=1 with the hold register when i_fifo_full=0, then go to REQ; otherwise remain in HOLD.
REQ-021 DISCARD: on i_ic_valid, drop the response with no FIFO write and go to REQ.
REQ-022 i_redirect SHALL have priority over every other event: pc<=i_redirect_addr with bits [1:0] forced to 0, o_ic_req=0, o_fifo_wr_en=0 in that cycle.
REQ-023 Redirect in REQ or HOLD: next state REQ; any held instruction is dropped.
REQ-024 Redirect in WAIT: next state DISCARD, or REQ if i_ic_valid=1 in the same cycle (response dropped).
REQ-025 Redirect in DISCARD: pc updated; stay DISCARD, or REQ if i_ic_valid=1 in the same cycle.
REQ-026 i_ic_valid in REQ or HOLD is a protocol violation: ignore it; no state change.
REQ-027 o_fifo_wr_en SHALL never assert while i_fifo_full=1.
REQ-028 Throughput: at most 1 instruction per 2 cycles; minimum fetch-to-FIFO latency is 1 cycle after ack when memory responds the next cycle.
REQ-029 Instructions SHALL reach the FIFO in program order, each exactly once, with PC matching its address.

Reset
REQ-030 While n_rst=0, asynchronously: state=REQ, pc=RESET_ADDR, req_pc=0, hold register=0; o_ic_req=0, o_fifo_wr_en=0.
REQ-031 First request: o_ic_req=1, o_ic_addr=RESET_ADDR in the first cycle after reset deassertion.
REQ-032 Reset asserted mid-operation (WAIT/HOLD/DISCARD) SHALL abandon any outstanding request; responses arriving during reset are ignored.

Verification
REQ-033 Memory acks immediately and responds 1 cycle later, FIFO never full -> FIFO writes {0x0,insn0}, {0x4,insn1}, {0x8,insn2} on every second cycle.
REQ-034 Response at 0x8 arrives with i_fifo_full=1 for 3 cycles -> state HOLD, no write; write {0x8,insn} in the first cycle full drops; next request is 0xC.
REQ-035 Redirect to 0x103 while in WAIT for 0x10; stale response arrives 2 cycles later -> stale response dropped; next o_ic_addr=0x100; FIFO receives 0x100 next.
REQ-036 Redirect coincident with i_ic_valid in WAIT -> no FIFO write; next cycle state REQ, o_ic_addr=redirect_addr.
REQ-037 pc=2^ADDR_WIDTH-4, ack -> next o_ic_addr=0x0.
REQ-038 n_rst pulsed low while in HOLD -> outputs 0 immediately; after release o_ic_addr=RESET_ADDR, and the held instruction is never written.
